mem_stream_ctrl: RTL

//   Stream-side controller for the 8-bit sync-write/async-read memory block.

---
 rtl/mem_stream_ctrl.sv | 79 +++++++
 1 files changed

// File: rtl/mem_stream_ctrl.sv
// Stream-side controller that turns an 8-bit sync-write/async-read memory into a FIFO.
// Upstream valid/ready bytes become memory writes; stored bytes drain in order downstream.
module mem_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_add,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  push;
  logic                  pop;

  // Pointers wrap at DEPTH-1 so addresses beyond the usable range are never driven.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Handshake decode; reset gates the write strobe so it drops immediately.
  always_comb begin
    full             = (count_q == DEPTH_CNT);
    empty            = (count_q == '0);
    in_ready         = !full && !flush;
    out_valid        = !empty;
    push             = in_valid && in_ready && !reset;
    pop              = out_valid && out_ready;
    mem_write_enable = push;
    mem_data_in      = in_data;
    mem_wr_addr      = wr_ptr;
    mem_rd_add       = rd_ptr;
    out_data         = mem_data_out;
    count            = count_q;
  end

  // Pointer and occupancy state; flush wins over any pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
